// File: rtl/epoch_sched.sv
// epoch_sched: sequences train and validate sample requests over a set number of epochs.
// When EPOCH_SCHED_EARLY_STOP_EN is defined, the run stops early once an epoch's validation error stops improving.
module epoch_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  n_train,
    input  logic [9:0]  n_val,
    input  logic [7:0]  n_epochs,
    input  logic        phase_done,
    input  logic [15:0] sample_err,
    output logic        TR,
    output logic        VL,
    output logic [9:0]  sample_addr,
    output logic [7:0]  epoch,
    output logic [25:0] val_err_sum,
    output logic        busy,
    output logic        done,
    output logic        stopped
);
    typedef enum logic [2:0] {IDLE, TR_ISSUE, TR_WAIT, VL_ISSUE, VL_WAIT, EP_END, DONE} state_t;
    state_t state, next;
    logic [9:0]  tr_n, vl_n;
    logic [7:0]  ep_n;
    logic [26:0] sum_ext;
    logic        last_tr, last_vl, last_ep, stop_now;
    assign TR      = state == TR_ISSUE;
    assign VL      = state == VL_ISSUE;
    assign busy    = state != IDLE && state != DONE;
    assign done    = state == DONE;
    assign last_tr = sample_addr == tr_n - 10'd1;
    assign last_vl = sample_addr == vl_n - 10'd1;
    assign last_ep = epoch + 8'd1 == ep_n;
    assign sum_ext = {1'b0, val_err_sum} + {11'd0, sample_err};
`ifdef EPOCH_SCHED_EARLY_STOP_EN
    logic [25:0] prev_err;
    assign stop_now = vl_n != 10'd0 && val_err_sum >= prev_err;
`else
    assign stop_now = 1'b0;
    assign stopped  = 1'b0;
`endif
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    // Next-state decode; abort wins over everything outside IDLE.
    always_comb begin
        next = state;
        if (state != IDLE && abort) next = IDLE;
        else begin
            case (state)
                IDLE:     if (start) next = (n_epochs == 8'd0 || (n_train == 10'd0 && n_val == 10'd0)) ? DONE :
                                            n_train == 10'd0 ? VL_ISSUE : TR_ISSUE;
                TR_ISSUE: next = TR_WAIT;
                TR_WAIT:  if (phase_done) next = !last_tr ? TR_ISSUE : vl_n != 10'd0 ? VL_ISSUE : EP_END;
                VL_ISSUE: next = VL_WAIT;
                VL_WAIT:  if (phase_done) next = last_vl ? EP_END : VL_ISSUE;
                EP_END:   next = (last_ep || stop_now) ? DONE : tr_n == 10'd0 ? VL_ISSUE : TR_ISSUE;
                DONE:     next = IDLE;
                default:  next = IDLE;
            endcase
        end
    end
    // Datapath: counters, latched configuration and error accumulation; frozen on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_n        <= '0;
            vl_n        <= '0;
            ep_n        <= '0;
            sample_addr <= '0;
            epoch       <= '0;
            val_err_sum <= '0;
`ifdef EPOCH_SCHED_EARLY_STOP_EN
            prev_err    <= '0;
            stopped     <= 1'b0;
`endif
        end else if (next != IDLE) begin
            case (state)
                IDLE: begin
                    tr_n        <= n_train;
                    vl_n        <= n_val;
                    ep_n        <= n_epochs;
                    sample_addr <= '0;
                    epoch       <= '0;
`ifdef EPOCH_SCHED_EARLY_STOP_EN
                    prev_err    <= '1;
                    stopped     <= 1'b0;
`endif
                end
                TR_WAIT: if (phase_done) sample_addr <= last_tr ? 10'd0 : sample_addr + 10'd1;
                VL_WAIT: if (phase_done) begin
                    val_err_sum <= sum_ext[26] ? '1 : sum_ext[25:0];
                    if (!last_vl) sample_addr <= sample_addr + 10'd1;
                end
                EP_END: begin
                    epoch       <= epoch + 8'd1;
                    sample_addr <= '0;
`ifdef EPOCH_SCHED_EARLY_STOP_EN
                    if (stop_now) stopped <= 1'b1;
                    else if (vl_n != 10'd0) prev_err <= val_err_sum;
`endif
                end
                default: ;
            endcase
            if (next == VL_ISSUE && state != VL_WAIT) val_err_sum <= '0;
        end
    end
endmodule

// File: tb/tb_epoch_sched.sv
// tb_epoch_sched: scoreboard bench for epoch_sched with a behavioural phase controller.
module tb_epoch_sched;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, phase_done = 0;
    logic [9:0]  n_train = 0, n_val = 0;
    logic [7:0]  n_epochs = 0;
    logic [15:0] sample_err = 0;
    logic        TR, VL, busy, done, stopped;
    logic [9:0]  sample_addr;
    logic [7:0]  epoch;
    logic [25:0] val_err_sum;

    epoch_sched dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_train(n_train),
                     .n_val(n_val), .n_epochs(n_epochs), .phase_done(phase_done), .sample_err(sample_err),
                     .TR(TR), .VL(VL), .sample_addr(sample_addr), .epoch(epoch), .val_err_sum(val_err_sum),
                     .busy(busy), .done(done), .stopped(stopped));

    always #5 clk = ~clk;

    logic [18:0] exp_q[$];
    logic [15:0] verr [0:7];
    int          pass_cnt = 0, tot_cnt = 0, tr_cnt, vl_cnt, done_cnt, busy_cnt, exp_tr, exp_vl;
    logic [7:0]  exp_ep;
    logic [25:0] exp_sum;
    logic        exp_stop;

    // Reference model: expected request sequence and end-of-run values.
    task automatic plan(input int nt, input int nv, input int ne);
        logic [25:0] sum;
`ifdef EPOCH_SCHED_EARLY_STOP_EN
        logic [25:0] prev = '1;
`endif
        exp_q.delete();
        exp_ep = 0; exp_stop = 0; exp_tr = 0; exp_vl = 0; exp_sum = 0;
        if (ne == 0 || (nt == 0 && nv == 0)) return;
        for (int e = 0; e < ne; e++) begin
            for (int i = 0; i < nt; i++) begin exp_q.push_back({1'b0, 10'(i), 8'(e)}); exp_tr++; end
            sum = 0;
            for (int j = 0; j < nv; j++) begin exp_q.push_back({1'b1, 10'(j), 8'(e)}); exp_vl++; sum += 26'(verr[j]); end
            exp_ep = 8'(e + 1);
            exp_sum = sum;
`ifdef EPOCH_SCHED_EARLY_STOP_EN
            if (nv != 0 && sum >= prev) begin exp_stop = 1; break; end
            if (nv != 0) prev = sum;
`endif
        end
    endtask

    task automatic kick(input int nt, input int nv, input int ne);
        plan(nt, nv, ne);
        @(negedge clk);
        n_train = 10'(nt); n_val = 10'(nv); n_epochs = 8'(ne); start = 1;
        @(posedge clk);
        #1 start = 0;
        n_train = 10'($urandom_range(1, 9)); n_val = 10'($urandom_range(1, 7)); n_epochs = 8'($urandom_range(1, 9));
    endtask

    // Phase controller plus scoreboard consumer; optionally aborts in TR_WAIT of a given sample.
    task automatic serve(input int budget, input int abort_addr);
        int cd = 0;
        bit fin = 0;
        logic [15:0] cur = 0;
        logic [18:0] got, want;
        tr_cnt = 0; vl_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            phase_done = 0; abort = 0; start = (c == 8);
            busy_cnt += int'(busy);
            if (done) begin done_cnt++; fin = 1; end
            else if (TR || VL) begin
                tr_cnt += int'(TR); vl_cnt += int'(VL);
                got = {VL, sample_addr, epoch};
                tot_cnt++;
                if (exp_q.size() == 0) $display("FAIL req_unexpected vl=%0d addr=%0d ep=%0d", VL, sample_addr, epoch);
                else begin
                    want = exp_q.pop_front();
                    if (got !== want) $display("FAIL req_seq got vl=%0d addr=%0d ep=%0d expected vl=%0d addr=%0d ep=%0d",
                                               got[18], got[17:8], got[7:0], want[18], want[17:8], want[7:0]);
                    else pass_cnt++;
                end
                if (VL && sample_addr == 0) begin
                    tot_cnt++;
                    if (val_err_sum !== 26'd0) $display("FAIL val_clear got %0d expected 0", val_err_sum);
                    else pass_cnt++;
                end
                if (TR && int'(sample_addr) == abort_addr) begin
                    @(negedge clk); abort = 1; phase_done = 1; start = 0;
                    @(negedge clk); abort = 0; phase_done = 0;
                    tot_cnt++;
                    if ({busy, done, TR, VL} !== 4'b0) $display("FAIL abort_idle got busy/done/tr/vl=%b expected 0000", {busy, done, TR, VL});
                    else pass_cnt++;
                    exp_q.delete();
                    fin = 1;
                end
                cd = 5; cur = verr[sample_addr[2:0]];
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin phase_done = 1; sample_err = cur; end
            end
        end
        start = 0; phase_done = 0;
        tot_cnt++;
        if (!fin) $display("FAIL timeout no done/abort within %0d cycles", budget);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        tot_cnt++;
        if ({TR, VL, busy, done, stopped, sample_addr, epoch, val_err_sum} !== 49'd0)
            $display("FAIL reset_outputs got %h expected 0", {TR, VL, busy, done, stopped, sample_addr, epoch, val_err_sum});
        else pass_cnt++;
    endtask

    task automatic test_run(input int nt, input int nv, input int ne);
        bit degen = ne == 0 || (nt == 0 && nv == 0);
        kick(nt, nv, ne);
        serve(800, -1);
        tot_cnt += 6;
        if (done_cnt != 1) $display("FAIL done_count got %0d expected 1", done_cnt); else pass_cnt++;
        if (tr_cnt != exp_tr || vl_cnt != exp_vl) $display("FAIL pulse_count got tr=%0d vl=%0d expected tr=%0d vl=%0d", tr_cnt, vl_cnt, exp_tr, exp_vl); else pass_cnt++;
        if (epoch !== exp_ep) $display("FAIL epoch got %0d expected %0d", epoch, exp_ep); else pass_cnt++;
        if (stopped !== exp_stop) $display("FAIL stopped got %0d expected %0d", stopped, exp_stop); else pass_cnt++;
        if (exp_q.size() != 0) $display("FAIL req_missing got %0d left expected 0", exp_q.size()); else pass_cnt++;
        if (degen && busy_cnt != 0) $display("FAIL busy_degen got %0d busy cycles expected 0", busy_cnt); else pass_cnt++;
        if (nv != 0 && !degen) begin
            tot_cnt++;
            if (val_err_sum !== exp_sum) $display("FAIL val_err_sum got %0d expected %0d", val_err_sum, exp_sum); else pass_cnt++;
        end
        @(negedge clk);
        tot_cnt++;
        if ({busy, done} !== 2'b00 || epoch !== exp_ep) $display("FAIL post_done got busy=%0d done=%0d epoch=%0d expected 0 0 %0d", busy, done, epoch, exp_ep);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        verr[0] = 100; verr[1] = 200;
        test_run(3, 2, 2);
    endtask

    task automatic test_degenerate;
        test_run(0, 0, 4);
        test_run(3, 2, 0);
    endtask

    task automatic test_single_phase;
        test_run(0, 2, 2);
        test_run(2, 0, 3);
    endtask

    task automatic test_abort;
        kick(3, 2, 2);
        serve(200, 1);
        tot_cnt++;
        if (done_cnt != 0) $display("FAIL abort_done got %0d done pulses expected 0", done_cnt); else pass_cnt++;
        test_run(3, 2, 2);
    endtask

    task automatic test_early_stop;
        verr[0] = 100; verr[1] = 200;
        test_run(1, 2, 5);
        verr[0] = 50; verr[1] = 20; verr[2] = 7;
        test_run(2, 3, 3);
    endtask

    task automatic test_reset_mid;
        verr[0] = 100; verr[1] = 200;
        kick(0, 2, 1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk); phase_done = 1; sample_err = 100;
        @(negedge clk); phase_done = 0;
        @(negedge clk);
        tot_cnt++;
        if ({busy, sample_addr, val_err_sum} !== {1'b1, 10'd1, 26'd100}) $display("FAIL mid_vl_wait got busy=%0d addr=%0d sum=%0d expected 1 1 100", busy, sample_addr, val_err_sum);
        else pass_cnt++;
        #2 rst_n = 0;
        #1;
        tot_cnt++;
        if ({TR, VL, busy, done, stopped, sample_addr, epoch, val_err_sum} !== 49'd0)
            $display("FAIL async_reset got %h expected 0", {TR, VL, busy, done, stopped, sample_addr, epoch, val_err_sum});
        else pass_cnt++;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); phase_done = ~phase_done; sample_err = 16'hffff; end
        @(negedge clk); phase_done = 0;
        tot_cnt++;
        if ({TR, VL, busy, done, sample_addr, epoch, val_err_sum} !== 48'd0)
            $display("FAIL post_reset_ignore got %h expected 0", {TR, VL, busy, done, sample_addr, epoch, val_err_sum});
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) verr[i] = 16'(10 * (i + 1));
        #1 test_reset;
        @(negedge clk); rst_n = 1;
        test_basic;
        test_degenerate;
        test_single_phase;
        test_abort;
        test_early_stop;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/epoch_sched.md
EPOCH_SCHED -- requirements
Module: epoch_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: begin run; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: synchronous cancel of a run.
REQ-005 SHALL have ports n_train [9:0], n_val [9:0] and n_epochs [7:0], all inputs: training-sample, validation-sample and epoch counts.
REQ-006 SHALL have port phase_done, input, 1 bit: one-cycle pulse from the phase controller when the current sample has finished.
REQ-007 SHALL have port sample_err, input, 16 bits: unsigned validation error, valid only with phase_done.
REQ-008 SHALL have ports TR and VL, outputs, 1 bit each: one-cycle train and validate request pulses to the phase controller.
REQ-009 SHALL have port sample_addr, output, 10 bits: current sample index.
REQ-010 SHALL have port epoch, output, 8 bits: count of completed epochs.
REQ-011 SHALL have port val_err_sum, output, 26 bits: accumulated validation error for the current or last epoch.
REQ-012 SHALL have ports busy, done and stopped, outputs, 1 bit each: run active; one-cycle completion pulse; early-stop flag.

Function
REQ-013 SHALL implement the states IDLE, TR_ISSUE, TR_WAIT, VL_ISSUE, VL_WAIT, EP_END and DONE; outputs SHALL be Moore (decoded from registered state).
REQ-014 In IDLE with start=1, SHALL latch n_train, n_val and n_epochs, clear epoch, clear stopped and set sample_addr=0.
- Degenerate configuration (n_epochs=0, or n_train=0 and n_val=0): go to DONE.
- n_train=0 otherwise: go to VL_ISSUE.
- All other cases: go to TR_ISSUE.
REQ-015 TR SHALL be 1 exactly while in TR_ISSUE, VL exactly while in VL_ISSUE; each ISSUE state lasts one cycle, then moves to its WAIT state.
REQ-016 phase_done SHALL be ignored in every state except TR_WAIT and VL_WAIT.
REQ-017 On phase_done in TR_WAIT, SHALL act as follows:
- sample_addr ≠ n_train−1: increment sample_addr and go to TR_ISSUE.
- sample_addr = n_train−1 and n_val ≠ 0: set sample_addr=0, clear val_err_sum and go to VL_ISSUE.
- sample_addr = n_train−1 and n_val = 0: go to EP_END.
REQ-018 On entry to VL_ISSUE from IDLE, SHALL also clear val_err_sum.
REQ-019 On phase_done in VL_WAIT, SHALL add sample_err to val_err_sum, saturating at 2^26−1, then:
- sample_addr ≠ n_val−1: increment sample_addr and go to VL_ISSUE.
- Otherwise: go to EP_END.
REQ-020 In EP_END, SHALL increment epoch and set sample_addr=0.
- epoch+1 = n_epochs: go to DONE.
- Otherwise: go to TR_ISSUE, or to VL_ISSUE (clearing val_err_sum) when n_train=0.
REQ-021 In DONE, SHALL assert done for one cycle and return to IDLE; val_err_sum, epoch and stopped SHALL hold until the next start.
REQ-022 busy SHALL be 1 in every state except IDLE and DONE.
REQ-023 start while busy SHALL be ignored; input count changes during a run SHALL have no effect.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with TR=VL=0 and busy=0, and SHALL NOT pulse done; abort takes priority over phase_done.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and set all outputs and registers to 0, regardless of any run in progress.

Configuration
REQ-026 With macro EPOCH_SCHED_EARLY_STOP_EN defined, SHALL do the following:
- Keep a 26-bit prev_err register, set to all-ones at start.
- In EP_END after a validation pass: if val_err_sum >= prev_err, set stopped=1 and go to DONE; otherwise load prev_err with val_err_sum.
REQ-027 Without EPOCH_SCHED_EARLY_STOP_EN, SHALL have no prev_err register, SHALL tie stopped to 0, and SHALL run all n_epochs.

Verification
REQ-028 n_train=3, n_val=2, n_epochs=2, phase_done 5 cycles after each request -> 6 TR and 4 VL pulses; per epoch sample_addr goes 0,1,2 then 0,1; epoch=2; a single done pulse.
REQ-029 Validation errors 100 and 200 -> val_err_sum=300 after the epoch; the next epoch's first VL_ISSUE clears it to 0.
REQ-030 n_train=0, n_val=0, n_epochs=4, start -> done the cycle after the start edge, no TR/VL, busy never 1.
REQ-031 abort in TR_WAIT with sample_addr=1 -> next cycle busy=0, no done; a subsequent start restarts at sample_addr=0, epoch=0.
REQ-032 EARLY_STOP_EN, n_epochs=5, epoch sums 300 then 300 -> done after epoch 2, stopped=1, epoch=2.
REQ-033 rst_n low mid-VL_WAIT -> all outputs 0 without a clock edge; phase_done pulses after release are ignored.
